// File: rtl/gzip_stream_pkg.sv
// Shared types and constants for the gzip stream front-end (arbiter and block splitter).
package gzip_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam int unsigned DEFAULT_BLOCK_LEN = 16384;

endpackage

// File: rtl/stream_block_arbiter_rr_arb2.sv
// Two-request round-robin pick: on a tie the source other than `last` wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    if (req[0] && req[1]) gnt = ~last;
    else                  gnt = req[1];
  end

endmodule

// File: rtl/stream_block_arbiter.sv
// Two-source stream scheduler ahead of the gzip block splitter; whole-stream grants, round-robin.
// Optional post-block idle gap is built only when BLOCK_GAP_EN is defined.
module stream_block_arbiter
  import gzip_stream_pkg::*;
#(
  parameter int unsigned BLOCK_LEN  = DEFAULT_BLOCK_LEN,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic       s0_eos,
  input  logic [7:0] s0_byte,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic       s1_eos,
  input  logic [7:0] s1_byte,
  output logic       s1_ready,
  output logic       o_en,
  output logic       o_eos,
  output logic [7:0] o_byte,
  output logic       o_sid
);

  localparam int unsigned CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_LEN - 1);

`ifdef BLOCK_GAP_EN
  localparam bit GAP_ON = (GAP_CYCLES != 0);
  localparam int unsigned GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          ended, ended_n;
`endif

  state_t        state, state_n;
  logic          grant, grant_n;
  logic          last_grant, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    req;
  logic          pick;
  logic          xfer;
  logic          x_eos;
  logic [7:0]    x_byte;
  logic          blk_end;

  assign req = {s1_valid, s0_valid};

  rr_arb2 u_arb (
    .req  (req),
    .last (last_grant),
    .gnt  (pick)
  );

  // Ready depends only on registered state, never on the requester's valid.
  assign s0_ready = (state == GRANT) && !grant;
  assign s1_ready = (state == GRANT) &&  grant;

  assign xfer    = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  assign x_eos   = grant ? s1_eos  : s0_eos;
  assign x_byte  = grant ? s1_byte : s0_byte;
  assign blk_end = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last_grant;
    cnt_n   = cnt;
`ifdef BLOCK_GAP_EN
    ended_n   = ended;
    gap_cnt_n = gap_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          grant_n = pick;
          state_n = GRANT;
`ifdef BLOCK_GAP_EN
          ended_n = 1'b0;
`endif
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_n = cnt + 1'b1;
          // eos on the last byte of a block is one block end, so it is tested first.
          if (x_eos) begin
            last_n  = grant;
            cnt_n   = '0;
            state_n = IDLE;
`ifdef BLOCK_GAP_EN
            ended_n = 1'b1;
            if (GAP_ON) begin
              state_n   = GAP;
              gap_cnt_n = GAP_LOAD;
            end
`endif
          end else if (blk_end) begin
            cnt_n = '0;
`ifdef BLOCK_GAP_EN
            ended_n = 1'b0;
            if (GAP_ON) begin
              state_n   = GAP;
              gap_cnt_n = GAP_LOAD;
            end
`endif
          end
        end
      end
`ifdef BLOCK_GAP_EN
      GAP: begin
        if (gap_cnt == '0) state_n = ended ? IDLE : GRANT;
        else               gap_cnt_n = gap_cnt - 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
`ifdef BLOCK_GAP_EN
      gap_cnt    <= '0;
      ended      <= 1'b0;
`endif
      o_en       <= 1'b0;
      o_eos      <= 1'b0;
      o_byte     <= '0;
      o_sid      <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_n;
      cnt        <= cnt_n;
`ifdef BLOCK_GAP_EN
      gap_cnt    <= gap_cnt_n;
      ended      <= ended_n;
`endif
      o_en       <= xfer;
      o_eos      <= xfer && x_eos;
      o_byte     <= xfer ? x_byte : '0;
      o_sid      <= xfer && grant;
    end
  end

endmodule
